// File: rtl/master_volume.sv
// Stereo master-gain stage: ramped Q1.7 gain on one shared multiplier (L then R),
// saturating output with a one-cycle valid pulse and a held clip indicator.
module master_volume #(
  parameter int DW        = 16,
  parameter int GW        = 8,
  parameter int CLIP_HOLD = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce_sample,
  input  logic signed [DW-1:0] in_l,
  input  logic signed [DW-1:0] in_r,
  input  logic [GW-1:0]        target_gain,
  input  logic                 mute,
  output logic signed [DW-1:0] out_l,
  output logic signed [DW-1:0] out_r,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 clip,
  output logic [GW-1:0]        cur_gain
);

  localparam int PW = DW + GW + 1;
  localparam int CW = $clog2(CLIP_HOLD + 1);
  localparam logic signed [PW-1:0] MAX_V = PW'((2 ** (DW - 1)) - 1);
  localparam logic signed [PW-1:0] MIN_V = ~MAX_V;

  // Handshake: ce_sample is a one-cycle strobe taken only while busy=0 (state IDLE);
  // strobes seen while busy=1 are dropped. out_valid pulses for exactly one cycle,
  // during which out_l/out_r hold the new sample.
  typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, OUT} state_t;
  state_t state, state_nxt;

  logic signed [DW-1:0] l_hold, r_hold, res_l, mul_a, sat_val;
  logic [GW-1:0]        gain_hold, eff_target;
  logic signed [PW-1:0] mul_ext, gain_ext, prod, scaled;
  logic                 sat_l, sat_hit, accept;
  logic [CW-1:0]        hold_cnt, hold_nxt;

  assign accept     = (state == IDLE) && ce_sample;
  assign busy       = (state != IDLE);
  assign eff_target = mute ? '0 : target_gain;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ce_sample) state_nxt = MUL_L;
      MUL_L:   state_nxt = MUL_R;
      MUL_R:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shared signed x unsigned multiplier; gain is zero-extended so it stays positive.
  always_comb begin
    mul_a    = (state == MUL_L) ? l_hold : r_hold;
    mul_ext  = {{(GW + 1){mul_a[DW-1]}}, mul_a};
    gain_ext = {{(DW + 1){1'b0}}, gain_hold};
    prod     = mul_ext * gain_ext;
    scaled   = prod >>> (GW - 1);
    sat_hit  = 1'b0;
    sat_val  = scaled[DW-1:0];
    if (scaled > MAX_V) begin
      sat_val = MAX_V[DW-1:0];
      sat_hit = 1'b1;
    end else if (scaled < MIN_V) begin
      sat_val = MIN_V[DW-1:0];
      sat_hit = 1'b1;
    end
  end

  // Saturation reloads the hold; otherwise each sample counts it down toward zero.
  always_comb begin
    hold_nxt = hold_cnt;
    if (sat_l || sat_hit)   hold_nxt = CW'(CLIP_HOLD);
    else if (hold_cnt != '0) hold_nxt = hold_cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      l_hold    <= '0;
      r_hold    <= '0;
      gain_hold <= '0;
      res_l     <= '0;
      sat_l     <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      clip      <= 1'b0;
      hold_cnt  <= '0;
      cur_gain  <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      if (accept) begin
        l_hold    <= in_l;
        r_hold    <= in_r;
        gain_hold <= cur_gain;
        if (cur_gain < eff_target)      cur_gain <= cur_gain + GW'(1);
        else if (cur_gain > eff_target) cur_gain <= cur_gain - GW'(1);
      end
      if (state == MUL_L) begin
        res_l <= sat_val;
        sat_l <= sat_hit;
      end
      // Results land on entry to OUT so they are stable for the whole valid cycle.
      if (state == MUL_R) begin
        out_l     <= res_l;
        out_r     <= sat_val;
        out_valid <= 1'b1;
        hold_cnt  <= hold_nxt;
        clip      <= (hold_nxt != '0);
      end
    end
  end

endmodule

// File: tb/tb_master_volume.sv
// Directed bench for master_volume: ramp, saturation/clip hold, rounding, mute,
// dropped strobes and asynchronous reset during a sample.
module tb_master_volume;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               ce_sample = 1'b0;
  logic signed [15:0] in_l = '0;
  logic signed [15:0] in_r = '0;
  logic [7:0]         target_gain = '0;
  logic               mute = 1'b0;
  logic signed [15:0] out_l, out_r;
  logic               out_valid, busy, clip;
  logic [7:0]         cur_gain;

  int checks = 0;
  int failures = 0;

  master_volume #(.DW(16), .GW(8), .CLIP_HOLD(4096)) dut (
    .clk(clk), .reset_n(reset_n), .ce_sample(ce_sample), .in_l(in_l), .in_r(in_r),
    .target_gain(target_gain), .mute(mute), .out_l(out_l), .out_r(out_r),
    .out_valid(out_valid), .busy(busy), .clip(clip), .cur_gain(cur_gain)
  );

  always #5 clk = ~clk;

  // Reference: floor(x*g/128), clamped to 16-bit signed.
  function automatic int ref_scale(input int x, input int g);
    int s;
    s = (x * g) >>> 7;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  // Issues one strobe from IDLE and returns what appeared on the valid cycle.
  // lat_ok is 0 unless out_valid is high exactly on the 3rd cycle after the strobe.
  task automatic do_sample(input logic signed [15:0] l, input logic signed [15:0] r,
                           output logic signed [15:0] ol, output logic signed [15:0] orr,
                           output logic cl, output logic lat_ok);
    lat_ok = 1'b1; ol = '0; orr = '0; cl = 1'b0;
    @(negedge clk);
    in_l = l; in_r = r; ce_sample = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      ce_sample = 1'b0;
      if (out_valid !== (k == 3)) lat_ok = 1'b0;
      if (k == 3) begin ol = out_l; orr = out_r; cl = clip; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_l !== 16'sd0 || out_r !== 16'sd0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        clip !== 1'b0 || cur_gain !== 8'h00) begin
      failures++;
      $display("FAIL reset_state got l=%0d r=%0d v=%0b b=%0b c=%0b g=%0h exp all zero",
               out_l, out_r, out_valid, busy, clip, cur_gain);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cur_gain !== 8'h00) begin
      failures++;
      $display("FAIL reset_release got b=%0b g=%0h exp b=0 g=0", busy, cur_gain);
    end
  endtask

  task automatic test_ramp_unity();
    logic signed [15:0] ol, orr;
    logic cl, lat;
    int eg;
    target_gain = 8'h80;
    for (int i = 0; i < 200; i++) begin
      eg = (i < 128) ? i : 128;
      checks++;
      if (cur_gain !== 8'(eg)) begin
        failures++;
        $display("FAIL ramp_gain[%0d] got=%0h exp=%0h", i, cur_gain, eg);
      end
      do_sample(16'sh1234, -16'sd5, ol, orr, cl, lat);
      checks++;
      if (lat !== 1'b1 || int'(ol) != ref_scale(16'h1234, eg) || int'(orr) != ref_scale(-5, eg)) begin
        failures++;
        $display("FAIL ramp_out[%0d] got l=%0d r=%0d lat=%0b exp l=%0d r=%0d lat=1",
                 i, ol, orr, lat, ref_scale(16'h1234, eg), ref_scale(-5, eg));
      end
    end
    checks++;
    if (ol !== 16'sh1234 || orr !== -16'sd5) begin
      failures++;
      $display("FAIL unity_passthrough got l=%0h r=%0d exp l=1234 r=-5", ol, orr);
    end
  endtask

  task automatic test_saturation_clip();
    logic signed [15:0] ol, orr;
    logic cl, lat;
    target_gain = 8'hFF;
    for (int i = 0; i < 127; i++) do_sample('0, '0, ol, orr, cl, lat);
    checks++;
    if (cur_gain !== 8'hFF || cl !== 1'b0) begin
      failures++;
      $display("FAIL sat_setup got g=%0h clip=%0b exp g=ff clip=0", cur_gain, cl);
    end
    do_sample(16'sh7000, -16'sh7000, ol, orr, cl, lat);
    checks++;
    if (ol !== 16'sd32767 || orr !== -16'sd32768 || cl !== 1'b1 || lat !== 1'b1) begin
      failures++;
      $display("FAIL saturate got l=%0d r=%0d clip=%0b lat=%0b exp l=32767 r=-32768 clip=1 lat=1",
               ol, orr, cl, lat);
    end
    for (int k = 1; k <= 4096; k++) begin
      do_sample(16'sd100, -16'sd100, ol, orr, cl, lat);
      checks++;
      if (cl !== (k < 4096)) begin
        failures++;
        $display("FAIL clip_hold[%0d] got=%0b exp=%0b", k, cl, (k < 4096));
      end
    end
  endtask

  task automatic test_rounding();
    logic signed [15:0] ol, orr;
    logic cl, lat;
    target_gain = 8'h40;
    for (int i = 0; i < 191; i++) do_sample('0, '0, ol, orr, cl, lat);
    checks++;
    if (cur_gain !== 8'h40) begin
      failures++;
      $display("FAIL round_setup got g=%0h exp g=40", cur_gain);
    end
    do_sample(-16'sd3, -16'sh8000, ol, orr, cl, lat);
    checks++;
    if (ol !== -16'sd2 || orr !== -16'sd16384) begin
      failures++;
      $display("FAIL round_neg got l=%0d r=%0d exp l=-2 r=-16384", ol, orr);
    end
    do_sample(16'sd3, 16'sd7, ol, orr, cl, lat);
    checks++;
    if (ol !== 16'sd1 || orr !== 16'sd3) begin
      failures++;
      $display("FAIL round_pos got l=%0d r=%0d exp l=1 r=3", ol, orr);
    end
  endtask

  task automatic test_mute();
    logic signed [15:0] ol, orr;
    logic cl, lat;
    target_gain = 8'h80;
    for (int i = 0; i < 64; i++) do_sample('0, '0, ol, orr, cl, lat);
    mute = 1'b1;
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (cur_gain !== 8'(128 - i)) begin
        failures++;
        $display("FAIL mute_gain[%0d] got=%0h exp=%0h", i, cur_gain, 128 - i);
      end
      do_sample(16'sh4000, -16'sh4000, ol, orr, cl, lat);
      checks++;
      if (int'(ol) != ref_scale(16'h4000, 128 - i) || int'(orr) != ref_scale(-16'h4000, 128 - i)) begin
        failures++;
        $display("FAIL mute_out[%0d] got l=%0d r=%0d exp l=%0d r=%0d", i, ol, orr,
                 ref_scale(16'h4000, 128 - i), ref_scale(-16'h4000, 128 - i));
      end
    end
    do_sample(16'sh4000, -16'sh4000, ol, orr, cl, lat);
    checks++;
    if (cur_gain !== 8'h00 || ol !== 16'sd0 || orr !== 16'sd0) begin
      failures++;
      $display("FAIL muted_zero got g=%0h l=%0d r=%0d exp g=0 l=0 r=0", cur_gain, ol, orr);
    end
    mute = 1'b0;
    for (int i = 0; i < 80; i++) do_sample('0, '0, ol, orr, cl, lat);
    mute = 1'b1;
    for (int i = 0; i < 16; i++) do_sample('0, '0, ol, orr, cl, lat);
    checks++;
    if (cur_gain !== 8'h40) begin
      failures++;
      $display("FAIL mute_mid got g=%0h exp g=40", cur_gain);
    end
    mute = 1'b0;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (cur_gain !== 8'(64 + j)) begin
        failures++;
        $display("FAIL reverse_gain[%0d] got=%0h exp=%0h", j, cur_gain, 64 + j);
      end
      do_sample(16'sd1000, '0, ol, orr, cl, lat);
      checks++;
      if (int'(ol) != ref_scale(1000, 64 + j)) begin
        failures++;
        $display("FAIL reverse_out[%0d] got=%0d exp=%0d", j, ol, ref_scale(1000, 64 + j));
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_busy, n_valid;
    logic signed [15:0] last_l;
    n_busy = 0; n_valid = 0; last_l = '0;
    target_gain = 8'hA0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy === 1'b1) n_busy++;
      if (out_valid === 1'b1) begin n_valid++; last_l = out_l; end
      ce_sample = (c < 16) && (c % 2 == 0);
      in_l = 16'(c * 100);
      in_r = '0;
    end
    ce_sample = 1'b0;
    checks++;
    if (n_valid != 4) begin
      failures++;
      $display("FAIL b2b_valid_count got=%0d exp=4", n_valid);
    end
    checks++;
    if (n_busy != 12) begin
      failures++;
      $display("FAIL b2b_busy_cycles got=%0d exp=12", n_busy);
    end
    checks++;
    if (cur_gain !== 8'h4C) begin
      failures++;
      $display("FAIL b2b_gain_steps got=%0h exp=4c", cur_gain);
    end
    checks++;
    if (last_l !== 16'sd703) begin
      failures++;
      $display("FAIL b2b_last_out got=%0d exp=703", last_l);
    end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] ol, orr;
    logic cl, lat, stray;
    target_gain = 8'hFF;
    for (int i = 0; i < 60; i++) do_sample('0, '0, ol, orr, cl, lat);
    do_sample(16'sh7FFF, 16'sd0, ol, orr, cl, lat);
    checks++;
    if (ol !== 16'sd32767 || cl !== 1'b1 || cur_gain !== 8'h89) begin
      failures++;
      $display("FAIL rst_setup got l=%0d clip=%0b g=%0h exp l=32767 clip=1 g=89", ol, cl, cur_gain);
    end
    @(negedge clk);
    in_l = 16'sh5000; in_r = 16'sh5000; ce_sample = 1'b1;
    @(negedge clk);
    ce_sample = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_flight got b=%0b v=%0b exp b=1 v=0", busy, out_valid);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (out_l !== 16'sd0 || out_r !== 16'sd0 || clip !== 1'b0 || cur_gain !== 8'h00 ||
        busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_async got l=%0d r=%0d c=%0b g=%0h b=%0b v=%0b exp all zero",
               out_l, out_r, clip, cur_gain, busy, out_valid);
    end
    stray = 1'b0;
    repeat (2) @(negedge clk) if (out_valid !== 1'b0) stray = 1'b1;
    reset_n = 1'b1;
    repeat (5) @(negedge clk) if (out_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    checks++;
    if (stray !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_valid got stray=%0b exp=0", stray);
    end
    do_sample(16'sh1000, -16'sh1000, ol, orr, cl, lat);
    checks++;
    if (lat !== 1'b1 || ol !== 16'sd0 || orr !== 16'sd0 || cur_gain !== 8'h01 || cl !== 1'b0) begin
      failures++;
      $display("FAIL rst_first got l=%0d r=%0d lat=%0b g=%0h c=%0b exp l=0 r=0 lat=1 g=1 c=0",
               ol, orr, lat, cur_gain, cl);
    end
    do_sample(16'sh1000, -16'sh1000, ol, orr, cl, lat);
    checks++;
    if (lat !== 1'b1 || ol !== 16'sd32 || orr !== -16'sd32) begin
      failures++;
      $display("FAIL rst_second got l=%0d r=%0d lat=%0b exp l=32 r=-32 lat=1", ol, orr, lat);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_unity();
    test_saturation_clip();
    test_rounding();
    test_mute();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
